// File: rtl/div_issue_if.sv
// div_issue_if: divider handshake bundle between the EX-stage issuer (master) and the multi-cycle divider (slave)
interface div_issue_if;
  logic [31:0] div_opdata1;
  logic [31:0] div_opdata2;
  logic        div_signed;
  logic        div_start;
  logic        div_annul;
  logic [63:0] div_result;
  logic        div_ready;
  modport master (
    output div_opdata1, div_opdata2, div_signed, div_start, div_annul,
    input  div_result, div_ready
  );
  modport slave (
    input  div_opdata1, div_opdata2, div_signed, div_start, div_annul,
    output div_result, div_ready
  );
endinterface

// File: rtl/div_issue.sv
// div_issue: EX-stage divider initiator; latches operands, stalls until the divider answers, writes HI/LO, aborts on flush/watchdog
module div_issue #(
  parameter int TIMEOUT_CYCLES = 48,
  parameter int CNT_W          = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_div_req,
  input  logic        i_signed,
  input  logic [31:0] i_reg1,
  input  logic [31:0] i_reg2,
  input  logic        i_flush,
  div_issue_if.master div,
  output logic        o_stallreq,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_whilo,
  output logic        o_timeout
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t r_state, w_next;
  logic [31:0] r_op1, r_op2, r_hi, r_lo;
  logic r_sgn, r_whilo, r_timeout;
  logic [CNT_W-1:0] r_cnt;
  logic w_issue, w_busy, w_to, w_cap, w_annul;
  assign w_issue = r_state == IDLE && i_div_req && !i_flush;
  assign w_busy  = r_state == BUSY;
  assign w_to    = w_busy && !i_flush && !div.div_ready && r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign w_cap   = w_busy && !i_flush && div.div_ready;
  assign w_annul = w_busy && (i_flush || w_to);
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_comb
    w_next = w_issue ? BUSY : !w_busy ? IDLE : w_annul ? IDLE : div.div_ready ? DONE : BUSY;
  always_comb begin
    div.div_annul = w_annul;
    div.div_start = w_busy && !w_annul;
    o_stallreq    = w_busy ? !(w_annul || div.div_ready) : i_div_req && !i_flush;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op1     <= '0;
      r_op2     <= '0;
      r_sgn     <= 1'b0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_whilo   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_issue) begin
        r_op1 <= i_reg1;
        r_op2 <= i_reg2;
        r_sgn <= i_signed;
        r_cnt <= '0;
      end else if (w_busy) r_cnt <= r_cnt + 1'b1;
      if (w_cap) begin
        r_hi <= div.div_result[63:32];
        r_lo <= div.div_result[31:0];
      end
      r_whilo   <= w_cap;
      r_timeout <= w_to;
    end
  end
  assign div.div_opdata1 = r_op1;
  assign div.div_opdata2 = r_op2;
  assign div.div_signed  = r_sgn;
  assign o_hi            = r_hi;
  assign o_lo            = r_lo;
  assign o_whilo         = r_whilo;
  assign o_timeout       = r_timeout;
endmodule

// File: tb/tb_div_issue.sv
// tb_div_issue: directed bench for div_issue with a behavioural divider peer and a HI/LO scoreboard
module tb_div_issue;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, sgn = 1'b0, flush = 1'b0, nready = 1'b0;
  logic [31:0] reg1 = '0, reg2 = '0, hi, lo;
  logic stall, whilo, tmo;
  int checks = 0, errors = 0, n_whilo = 0, dcnt = 0;
  logic [63:0] exp_q[$];
  div_issue_if dif();
  div_issue dut (
    .clk(clk), .rst(rst), .i_div_req(req), .i_signed(sgn), .i_reg1(reg1), .i_reg2(reg2),
    .i_flush(flush), .div(dif), .o_stallreq(stall), .o_hi(hi), .o_lo(lo),
    .o_whilo(whilo), .o_timeout(tmo)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] div_calc(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 64'd0;
    if (s) return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    return {a % b, a / b};
  endfunction
  always @(posedge clk)
    if (rst || !dif.div_start || dif.div_annul) begin
      dcnt <= 0;
      dif.div_ready <= 1'b0;
      dif.div_result <= '0;
    end else if (dcnt == 33 && !nready) begin
      dif.div_ready <= 1'b1;
      dif.div_result <= div_calc(dif.div_signed, dif.div_opdata1, dif.div_opdata2);
    end else dcnt <= dcnt + 1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(negedge clk)
    if (whilo) begin
      logic [63:0] e;
      n_whilo++;
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_hi", 64'(hi), 64'(e[63:32]));
        chk("sb_lo", 64'(lo), 64'(e[31:0]));
      end
    end
  task automatic cyc;
    @(negedge clk);
    #1;
  endtask
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    req = 1'b1;
    sgn = s;
    reg1 = a;
    reg2 = b;
  endtask
  task automatic wait_done(input logic s, input logic [31:0] a, input logic [31:0] b);
    int k;
    for (k = 0; k < 100; k++) begin
      cyc();
      if (dif.div_start) begin
        chk("op1_stable", 64'(dif.div_opdata1), 64'(a));
        chk("op2_stable", 64'(dif.div_opdata2), 64'(b));
        chk("sgn_stable", 64'(dif.div_signed), 64'(s));
        if (dif.div_ready) break;
      end
      chk("stall_wait", 64'(stall), 64'd1);
    end
    chk("ready_seen", 64'(k < 100), 64'd1);
    chk("stall_ready", 64'(stall), 64'd0);
  endtask
  task automatic single(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int nw);
    issue(s, a, b);
    exp_q.push_back({ehi, elo});
    #1;
    chk("stall_issue", 64'(stall), 64'd1);
    wait_done(s, a, b);
    req = 1'b0;
    cyc();
    chk("stall_done", 64'(stall), 64'd0);
    chk("whilo_count", 64'(n_whilo), 64'(nw));
    cyc();
    chk("whilo_pulse", 64'(whilo), 64'd0);
    chk("no_timeout", 64'(tmo), 64'd0);
    chk("hi_hold", 64'(hi), 64'(ehi));
    chk("lo_hold", 64'(lo), 64'(elo));
  endtask
  initial begin
    repeat (3) cyc();
    chk("rst_start", 64'(dif.div_start), 64'd0);
    chk("rst_annul", 64'(dif.div_annul), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_pulses", 64'({whilo, tmo}), 64'd0);
    chk("rst_ops", {dif.div_opdata1, dif.div_opdata2}, 64'd0);
    chk("rst_sgn", 64'(dif.div_signed), 64'd0);
    rst = 1'b0;
    cyc();
    single(1'b0, 32'd7, 32'd2, 32'd1, 32'd3, 1);
    single(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 2);
    single(1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 3);
    // back-to-back: second request waits through DONE
    issue(1'b0, 32'd100, 32'd7);
    exp_q.push_back({32'd2, 32'd14});
    #1;
    chk("b2b_stall_issue", 64'(stall), 64'd1);
    wait_done(1'b0, 32'd100, 32'd7);
    issue(1'b0, 32'd9, 32'd3);
    exp_q.push_back({32'd0, 32'd3});
    cyc();
    chk("b2b_stall_done", 64'(stall), 64'd1);
    chk("b2b_start_done", 64'(dif.div_start), 64'd0);
    wait_done(1'b0, 32'd9, 32'd3);
    req = 1'b0;
    cyc();
    chk("b2b_whilo_count", 64'(n_whilo), 64'd5);
    cyc();
    chk("b2b_hilo", {hi, lo}, {32'd0, 32'd3});
    // flush in the 10th BUSY cycle
    issue(1'b0, 32'd1000, 32'd3);
    #1;
    repeat (10) cyc();
    chk("flush_start_before", 64'(dif.div_start), 64'd1);
    flush = 1'b1;
    req = 1'b0;
    #1;
    chk("flush_annul", 64'(dif.div_annul), 64'd1);
    chk("flush_start", 64'(dif.div_start), 64'd0);
    chk("flush_stall", 64'(stall), 64'd0);
    cyc();
    flush = 1'b0;
    #1;
    chk("flush_annul_drop", 64'(dif.div_annul), 64'd0);
    chk("flush_idle", 64'(dif.div_start), 64'd0);
    repeat (40) cyc();
    chk("flush_no_write", 64'(n_whilo), 64'd5);
    chk("flush_hilo_hold", {hi, lo}, {32'd0, 32'd3});
    // watchdog: divider never answers
    nready = 1'b1;
    issue(1'b0, 32'd50, 32'd5);
    #1;
    begin
      int k;
      for (k = 1; k <= 100; k++) begin
        cyc();
        if (dif.div_annul) break;
      end
      chk("to_busy_cycles", 64'(k), 64'd48);
    end
    chk("to_stall", 64'(stall), 64'd0);
    chk("to_pulse_early", 64'(tmo), 64'd0);
    req = 1'b0;
    cyc();
    chk("to_pulse", 64'(tmo), 64'd1);
    chk("to_annul_drop", 64'(dif.div_annul), 64'd0);
    cyc();
    chk("to_pulse_drop", 64'(tmo), 64'd0);
    chk("to_no_write", 64'(n_whilo), 64'd5);
    nready = 1'b0;
    // reset while BUSY
    issue(1'b1, 32'd20, 32'd4);
    #1;
    repeat (5) cyc();
    rst = 1'b1;
    req = 1'b0;
    cyc();
    chk("rstb_start", 64'(dif.div_start), 64'd0);
    chk("rstb_ops", {dif.div_opdata1, dif.div_opdata2}, 64'd0);
    chk("rstb_stall", 64'(stall), 64'd0);
    chk("rstb_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    repeat (40) cyc();
    chk("rstb_no_write", 64'(n_whilo), 64'd5);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
